// File: rtl/output_unit_pkg.sv
// Shared constants for the output FIFO and the status register block that
// reports its sticky flags.
package output_unit_pkg;

  // Default geometry of the output FIFO.
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Bit position of the sticky overflow flag in the status register.
  localparam int STAT_OVERFLOW_BIT = 0;

  // Number of entries in the output stage (head plus skid).
  localparam int OUT_STAGE_DEPTH = 2;

endpackage : output_unit_pkg

// File: rtl/output_ram_sdp.sv
// Simple-dual-port storage: one synchronous write port and one read port
// with a registered address/data path. No reset, so it maps onto block RAM.
module output_ram_sdp
  import output_unit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read; data is valid the cycle after i_re.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : output_ram_sdp

// File: rtl/output_fifo_unit.sv
// RAM-backed output FIFO with a two-entry output stage that hides the RAM
// read latency, plus flush, occupancy and sticky overflow reporting.
module output_fifo_unit
  import output_unit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_ram_cnt;
  logic              r_inflight;
  logic [1:0]        r_out_cnt;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_skid;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_overflow;

  logic              w_clear;
  logic              w_wr_acc;
  logic              w_pop;
  logic [2:0]        w_stage_load;
  logic              w_rd_issue;
  logic [DATA_W-1:0] w_ram_q;
  logic [ADDR_W:0]   w_count_nxt;
  logic [ADDR_W:0]   w_ram_cnt_nxt;

  assign w_clear  = rst | flush;
  assign rd_valid = (r_out_cnt != 2'd0);
  assign w_wr_acc = wr_en & ~r_full;
  assign w_pop    = rd_valid & rd_ready;

  // Words already committed to the output stage after this cycle's pop;
  // a read is issued only if it will have somewhere to land.
  assign w_stage_load = {1'b0, r_out_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};

  // The RAM count used here is the value before this cycle's write, so the
  // read address can never equal the write address in the same cycle.
  assign w_rd_issue = (r_ram_cnt != '0) && (w_stage_load < 3'(OUT_STAGE_DEPTH));

  output_ram_sdp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_re    (w_rd_issue),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_q)
  );

  // Next total occupancy: a simultaneous write and pop cancel out.
  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (!w_wr_acc && w_pop) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  // Next RAM-resident word count: writes add, issued reads remove.
  always_comb begin
    w_ram_cnt_nxt = r_ram_cnt;
    if (w_wr_acc && !w_rd_issue) begin
      w_ram_cnt_nxt = r_ram_cnt + CNT_ONE;
    end else if (!w_wr_acc && w_rd_issue) begin
      w_ram_cnt_nxt = r_ram_cnt - CNT_ONE;
    end
  end

  // Write/read pointers, RAM count and the in-flight read marker.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_issue) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_ram_cnt  <= w_ram_cnt_nxt;
      r_inflight <= w_rd_issue;
    end
  end

  // Output stage: skid shifts into head on pop, a landing RAM word takes the
  // first entry that is free after the pop.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_out_cnt <= 2'd0;
      r_head    <= '0;
      r_skid    <= '0;
    end else begin
      unique case ({w_pop, r_inflight})
        2'b11: begin
          if (r_out_cnt == 2'd2) begin
            r_head <= r_skid;
            r_skid <= w_ram_q;
          end else begin
            r_head <= w_ram_q;
          end
        end
        2'b10: begin
          r_head    <= r_skid;
          r_out_cnt <= r_out_cnt - 2'd1;
        end
        2'b01: begin
          if (r_out_cnt == 2'd0) begin
            r_head <= w_ram_q;
          end else begin
            r_skid <= w_ram_q;
          end
          r_out_cnt <= r_out_cnt + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Occupancy, registered full flag and sticky overflow.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign rd_data  = r_head;
  assign full     = r_full;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule : output_fifo_unit

// File: tb/tb_output_fifo_unit.sv
module tb_output_fifo_unit;

  localparam int DW = 8;
  localparam int DP = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         wr_en = 1'b1;
  logic [DW-1:0] wr_data = 8'h77;
  logic         full;
  logic         rd_valid;
  logic         rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [4:0]   count;
  logic         overflow;

  output_fifo_unit #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  int  m_count = 0;
  bit  m_ovf = 1'b0;
  bit  m_live = 1'b0;
  int  pop_total = 0;
  bit  stream_mode = 1'b0;
  bit  prev_pop = 1'b0;
  int  n_runs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs; an accepted write pushes its expected word.
  task automatic drive(input logic we, input logic [DW-1:0] d, input logic rr);
    wr_en    = we;
    wr_data  = d;
    rd_ready = rr;
    if (we && !rst && !flush && m_count != DP) exp_q.push_back(d);
  endtask

  // Monitor: per-cycle occupancy/flag model and in-order data check on pop.
  always @(negedge clk) begin
    bit pop;
    bit acc;
    if (m_live) begin
      chk("count", 32'(count), 32'(m_count));
      chk("full", 32'(full), 32'(m_count == DP));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
    if (rst || flush) begin
      m_count = 0;
      m_ovf   = 1'b0;
      exp_q.delete();
      m_live  = 1'b1;
      prev_pop = 1'b0;
    end else if (m_live) begin
      pop = rd_valid && rd_ready;
      if (pop) begin
        pop_total++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pop_unexpected: got %0h expected no word", rd_data);
        end else begin
          chk("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
      end
      if (stream_mode) begin
        if (pop && !prev_pop) n_runs++;
        prev_pop = pop;
      end
      acc = wr_en && (m_count != DP);
      if (wr_en && m_count == DP) m_ovf = 1'b1;
      m_count = m_count + int'(acc) - int'(pop);
    end
  end

  initial begin
    int target;
    // Reset held 3 cycles with a write request present.
    repeat (3) step();
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_data", 32'(rd_data), 0);
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    repeat (3) step();
    chk("rst_nothing_stored", 32'(rd_valid), 0);

    // First-word latency.
    drive(1'b1, 8'hA5, 1'b0);
    step();                                   // E0
    drive(1'b0, 8'h00, 1'b0);
    chk("lat_e0_valid", 32'(rd_valid), 0);
    step();                                   // E1
    chk("lat_e1_valid", 32'(rd_valid), 0);
    chk("lat_e1_count", 32'(count), 1);
    step();                                   // E2
    chk("lat_e2_valid", 32'(rd_valid), 1);
    chk("lat_e2_data", 32'(rd_data), 32'hA5);
    drive(1'b0, 8'h00, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0);
    chk("lat_drained", 32'(count), 0);

    // Fill to capacity, then one dropped write.
    for (int i = 0; i < DP; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      step();
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    drive(1'b1, 8'hFF, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0);
    chk("fill_overflow", 32'(overflow), 1);
    chk("fill_count_hold", 32'(count), 16);
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 40 && count != 0; i++) step();
    drive(1'b0, 8'h00, 1'b0);
    chk("fill_drained", 32'(count), 0);
    chk("fill_queue_empty", 32'(exp_q.size()), 0);
    chk("fill_ovf_sticky", 32'(overflow), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ovf_clear", 32'(overflow), 0);

    // Streaming across several pointer wraps.
    stream_mode = 1'b1;
    n_runs = 0;
    target = pop_total + 100;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      step();
      chk("stream_cnt_le3", 32'(count <= 5'd3), 1);
      chk("stream_not_full", 32'(full), 0);
    end
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 10 && pop_total != target; i++) step();
    stream_mode = 1'b0;
    chk("stream_all_popped", 32'(pop_total), 32'(target));
    chk("stream_no_bubbles", 32'(n_runs), 1);

    // Random write/backpressure mix.
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      step();
    end
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 40 && (count != 0 || exp_q.size() != 0); i++) step();
    chk("bp_drained", 32'(count), 0);
    chk("bp_queue_empty", 32'(exp_q.size()), 0);

    // Flush mid-stream.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'h50 + i), 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b1);
    step();
    step();
    flush = 1'b1;
    drive(1'b1, 8'hEE, 1'b1);
    exp_q.delete();
    step();
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    chk("flush_valid", 32'(rd_valid), 0);
    chk("flush_count", 32'(count), 0);
    chk("flush_ovf", 32'(overflow), 0);
    drive(1'b1, 8'h3C, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0);
    step();
    chk("post_flush_e1_valid", 32'(rd_valid), 0);
    step();
    chk("post_flush_e2_valid", 32'(rd_valid), 1);
    chk("post_flush_e2_data", 32'(rd_data), 32'h3C);
    chk("post_flush_count", 32'(count), 1);
    drive(1'b0, 8'h00, 1'b1);
    step();
    chk("post_flush_sole", 32'(rd_valid), 0);
    repeat (3) step();
    chk("post_flush_empty", 32'(count), 0);
    chk("end_queue_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_output_fifo_unit
